serial_adder_ctrl: RTL and testbench

//   Bit-serial WIDTH-bit adder controller wrapped around one full_gate full-adder cell.

---
 rtl/serial_pkg.sv | 15 +
 rtl/serial_adder_ctrl_if.sv | 37 +++
 rtl/full_gate.sv | 19 +
 rtl/serial_adder_ctrl.sv | 119 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// serial_pkg
//   Shared definitions for the bit-serial adder controller:
//   - WIDTH_DEF : default operand/sum width
//   - state_t   : FSM state encoding (IDLE=0, RUN=1, DONE=2; 3 is unused)
package serial_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if
//   Request/result bundle of the serial adder controller.
//   master : drives start/opA/opB/cin, observes busy/done/sum/cout
//   slave  : the controller side
//   Signals:
//     start  request pulse (only honoured when the controller is idle or done)
//     opA    operand A, WIDTH bits
//     opB    operand B, WIDTH bits
//     cin    carry-in
//     busy   high while an add is shifting
//     done   one-cycle pulse, sum/cout valid
//     sum    WIDTH-bit result, held between adds
//     cout   carry-out, held like sum
interface serial_adder_ctrl_if #(
  parameter int WIDTH = serial_pkg::WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, opA, opB, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, opA, opB, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/full_gate.sv
// full_gate
//   One-bit full-adder cell (purely combinational).
//   Ports:
//     inA, inB  addend bits
//     Cin       carry in
//     outS2     sum bit
//     Cout0     carry out
module full_gate (
  input  logic inA,
  input  logic inB,
  input  logic Cin,
  output logic outS2,
  output logic Cout0
);

  assign outS2 = inA ^ inB ^ Cin;
  assign Cout0 = (inA & inB) | (inA & Cin) | (inB & Cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial WIDTH-bit adder built around a single full_gate cell.
//   On an accepted start the operands and carry-in are loaded; each RUN cycle
//   presents the LSBs of the operand shift registers and the carry flop to the
//   cell, shifts the sum bit into the top of the sum register and captures the
//   carry. After WIDTH bit-cycles the result is latched into sum/cout and done
//   pulses for one cycle. A new start in DONE chains straight into the next add.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  serial_adder_ctrl_if.slave (start/opA/opB/cin in, busy/done/sum/cout out)
module serial_adder_ctrl
  import serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   s_sh_q, s_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic               s_bit;
  logic               c_bit;

  full_gate u_full_gate (
    .inA   (a_sh_q[0]),
    .inB   (b_sh_q[0]),
    .Cin   (carry_q),
    .outS2 (s_bit),
    .Cout0 (c_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      // IDLE and DONE accept a request identically; DONE falls back to IDLE
      // when nothing is pending, which gives back-to-back adds for free.
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          a_sh_d  = bus.opA;
          b_sh_d  = bus.opB;
          carry_d = bus.cin;
          cnt_d   = '0;
          s_sh_d  = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        carry_d = c_bit;
        s_sh_d  = {s_bit, s_sh_q[WIDTH-1:1]};
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        // Last bit: publish the fully shifted sum register (including this
        // cycle's bit) and the final carry straight to the held outputs.
        if (cnt_q == CNT_LAST) begin
          sum_d   = s_sh_d;
          cout_d  = c_bit;
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
//   Self-checking bench for serial_adder_ctrl (WIDTH=8). Stimulus changes on
//   the falling edge; outputs are sampled on the falling edge. Expected
//   results come from plain integer addition of the operands.
module tb_serial_adder_ctrl;

  localparam int W = 8;
  localparam int LAT = W + 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic done_prev;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    int r;
    r = int'(a) + int'(b) + int'(c);
    return r[W:0];
  endfunction

  // done must never be high on two consecutive samples
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      checks++;
      if (done_prev === 1'b1) begin
        errors++;
        $display("FAIL done_twice: done=%b on two consecutive cycles, required single pulse", bus.done);
      end
    end
    done_prev <= bus.done;
  end

  // Runs one add; returns the captured result and the number of rising edges
  // from the accepting edge (inclusive) to the first sample showing done.
  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output logic [W-1:0] s, output logic co, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.opA   = a;
    bus.opB   = b;
    bus.cin   = c;
    @(negedge clk);
    bus.start = 1'b0;
    bus.opA   = W'($urandom);
    bus.opB   = W'($urandom);
    bus.cin   = 1'($urandom);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    s  = bus.sum;
    co = bus.cout;
    $display("add %02h + %02h + %0d -> sum=%02h cout=%0d latency=%0d", a, b, c, s, co, lat);
  endtask

  task automatic test_reset();
    logic [W-1:0] s;
    logic co;
    int lat;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 8'h00 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0",
               bus.busy, bus.done, bus.sum, bus.cout);
    end
    rst = 1'b0;
    do_add(8'h00, 8'h00, 1'b0, s, co, lat);
    checks++;
    if ({co, s} !== 9'h000) begin
      errors++;
      $display("FAIL zero_add: got %b/%h, required 0/00", co, s);
    end
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL latency: got %0d, required %0d", lat, LAT);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4] = '{8'h3C, 8'hFF, 8'hA5, 8'hFF};
    logic [W-1:0] vb [4] = '{8'h42, 8'h01, 8'h5A, 8'hFF};
    logic         vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [W:0]   vexp [4] = '{9'h07E, 9'h100, 9'h100, 9'h1FF};
    logic [W-1:0] s;
    logic co;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_add(va[i], vb[i], vc[i], s, co, lat);
      checks++;
      if ({co, s} !== vexp[i]) begin
        errors++;
        $display("FAIL directed_%0d: got %b/%h, required %b/%h", i, co, s, vexp[i][W], vexp[i][W-1:0]);
      end
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL directed_lat_%0d: got %0d, required %0d", i, lat, LAT);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s;
    logic c, co;
    logic [W:0] exp;
    int lat;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom);
      exp = ref_add(a, b, c);
      do_add(a, b, c, s, co, lat);
      checks++;
      if ({co, s} !== exp || lat !== LAT) begin
        errors++;
        $display("FAIL random_%0d: got %b/%h lat %0d, required %b/%h lat %0d",
                 i, co, s, lat, exp[W], exp[W-1:0], LAT);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [W:0] exp;
    int busy_cnt;
    int n;
    exp = ref_add(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.opA   = 8'h12;
    bus.opB   = 8'h34;
    bus.cin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt  = 0;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy === 1'b1) busy_cnt++;
      n++;
      if (n == 3) begin
        bus.start = 1'b1;
        bus.opA   = 8'hFF;
        bus.opB   = 8'hFF;
        bus.cin   = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    $display("ignore_start: sum=%02h cout=%0d busy_cycles=%0d", bus.sum, bus.cout, busy_cnt);
    checks++;
    if ({bus.cout, bus.sum} !== exp) begin
      errors++;
      $display("FAIL ignore_start_result: got %b/%h, required %b/%h",
               bus.cout, bus.sum, exp[W], exp[W-1:0]);
    end
    checks++;
    if (busy_cnt !== W) begin
      errors++;
      $display("FAIL busy_cycles: got %0d, required %0d", busy_cnt, W);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] a, b, s;
    logic c, co;
    logic [W:0] exp;
    int lat;
    int done_seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.opA   = 8'h77;
    bus.opB   = 8'h19;
    bus.cin   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    $display("reset_mid_run: busy=%0d done=%0d sum=%02h cout=%0d", bus.busy, bus.done, bus.sum, bus.cout);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 8'h00 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0",
               bus.busy, bus.done, bus.sum, bus.cout);
    end
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL no_done_after_reset: got %0d pulses, required 0", done_seen);
    end
    a = W'($urandom);
    b = W'($urandom);
    c = 1'($urandom);
    exp = ref_add(a, b, c);
    do_add(a, b, c, s, co, lat);
    checks++;
    if ({co, s} !== exp || lat !== LAT) begin
      errors++;
      $display("FAIL add_after_reset: got %b/%h lat %0d, required %b/%h lat %0d",
               co, s, lat, exp[W], exp[W-1:0], LAT);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    logic held_ok;
    @(negedge clk);
    bus.start = 1'b1;
    bus.opA   = 8'h01;
    bus.opB   = 8'h01;
    bus.cin   = 1'b0;
    @(negedge clk);
    bus.opA = 8'h10;
    bus.opB = 8'h20;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    $display("back_to_back first: sum=%02h cout=%0d latency=%0d", bus.sum, bus.cout, lat);
    checks++;
    if ({bus.cout, bus.sum} !== 9'h002 || lat !== LAT) begin
      errors++;
      $display("FAIL b2b_first: got %b/%h lat %0d, required 0/02 lat %0d",
               bus.cout, bus.sum, lat, LAT);
    end
    @(negedge clk);
    bus.start = 1'b0;
    gap = 1;
    held_ok = 1'b1;
    while (bus.done !== 1'b1 && gap < 40) begin
      if (bus.sum !== 8'h02) held_ok = 1'b0;
      @(negedge clk);
      gap++;
    end
    $display("back_to_back second: sum=%02h cout=%0d gap=%0d", bus.sum, bus.cout, gap);
    checks++;
    if (held_ok !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hold: sum changed before second done, required 02 held");
    end
    checks++;
    if (gap !== LAT) begin
      errors++;
      $display("FAIL b2b_gap: got %0d, required %0d", gap, LAT);
    end
    checks++;
    if ({bus.cout, bus.sum} !== 9'h030) begin
      errors++;
      $display("FAIL b2b_second: got %b/%h, required 0/30", bus.cout, bus.sum);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    done_prev = 1'b0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.opA   = '0;
    bus.opB   = '0;
    bus.cin   = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
